// File: rtl/tt_add_arb.sv
// tt_add_arb: round-robin arbiter sharing one W-bit adder among NREQ requesters.
// Optional build macro TT_ADD_ARB_SAT_EN saturates resp_sum to all-ones on carry.
module tt_add_arb #(
    parameter  int NREQ = 4,
    parameter  int W    = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [W-1:0]      resp_sum,
    output logic              resp_carry,
    output logic [IDW-1:0]    resp_id,
    output logic [15:0]       op_count,
    output logic              busy
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] gidx;
    logic [IDW-1:0] idx;
    logic           grant;
    logic           slot_free;
    logic [W-1:0]   a_arr [NREQ];
    logic [W-1:0]   b_arr [NREQ];
    logic [W-1:0]   a_sel, b_sel;
    logic [W:0]     sum_full;
    logic [W-1:0]   sum_out;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*W +: W];
        assign b_arr[i] = req_b[i*W +: W];
    end

    assign resp_valid = (state == FULL);
    assign slot_free  = !resp_valid || resp_ready;
    assign busy       = resp_valid || (|req_valid);

    // First valid index at or after ptr, wrapping; nothing granted in reset.
    always_comb begin
        grant     = 1'b0;
        gidx      = '0;
        idx       = '0;
        req_ready = '0;
        if (!rst && slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = IDW'((int'(ptr) + k) % NREQ);
                if (!grant && req_valid[idx]) begin
                    grant = 1'b1;
                    gidx  = idx;
                end
            end
        end
        if (grant) req_ready = NREQ'(1) << gidx;
    end

    assign a_sel    = a_arr[gidx];
    assign b_sel    = b_arr[gidx];
    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef TT_ADD_ARB_SAT_EN
    assign sum_out = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
    assign sum_out = sum_full[W-1:0];
`endif

    assign ptr_nxt = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (grant) state_nxt = FULL;
            FULL:  if (resp_ready && !grant) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            ptr        <= '0;
            resp_sum   <= '0;
            resp_carry <= 1'b0;
            resp_id    <= '0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                resp_sum   <= sum_out;
                resp_carry <= sum_full[W];
                resp_id    <= gidx;
                ptr        <= ptr_nxt;
            end
            if (resp_valid && resp_ready) op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_tt_add_arb.sv
// tb_tt_add_arb: directed stimulus with a response scoreboard for tt_add_arb.
// Expected carry-case sums follow TT_ADD_ARB_SAT_EN when defined.
module tb_tt_add_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [W-1:0]      resp_sum;
    logic              resp_carry;
    logic [IDW-1:0]    resp_id;
    logic [15:0]       op_count;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected response packed as {sum, carry, id}.
    logic [W+IDW:0] exp_q[$];

    always #5 clk = ~clk;

    tt_add_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_carry (resp_carry),
        .resp_id    (resp_id),
        .op_count   (op_count),
        .busy       (busy)
    );

`ifdef TT_ADD_ARB_SAT_EN
    localparam logic [7:0] S_F0_20 = 8'hFF;
    localparam logic [7:0] S_FF_01 = 8'hFF;
`else
    localparam logic [7:0] S_F0_20 = 8'h10;
    localparam logic [7:0] S_FF_01 = 8'h00;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a,
                          input logic [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic logic [W+IDW:0] pk(input logic [7:0] s, input logic c,
                                          input logic [1:0] id);
        return {s, c, id};
    endfunction

    // Scoreboard monitor: a response is consumed when valid and ready meet.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_resp", {21'd0, resp_sum, resp_carry, resp_id}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_resp", {21'd0, resp_sum, resp_carry, resp_id},
                    {21'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 4'hF;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        @(negedge clk);
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        step();
        step();
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_resp_sum", {23'd0, resp_sum, resp_carry}, 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);

        // Single request
        step();
        rst        = 1'b0;
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        set_op(0, 8'h12, 8'h34);
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h1);
        exp_q.push_back(pk(8'h46, 1'b0, 2'd0));
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 32'(resp_valid), 32'h1);
        step();
        @(negedge clk);
        chk("single_count", 32'(op_count), 32'h1);
        chk("single_empty", 32'(resp_valid), 32'h0);

        // Carry on requester 1, then requester 3 (ptr ends at 0)
        step();
        req_valid = 4'b0010;
        set_op(1, 8'hF0, 8'h20);
        @(negedge clk);
        chk("carry_ready", 32'(req_ready), 32'h2);
        exp_q.push_back(pk(S_F0_20, 1'b1, 2'd1));
        step();
        req_valid = 4'b1000;
        set_op(3, 8'hFF, 8'h01);
        @(negedge clk);
        chk("carry3_ready", 32'(req_ready), 32'h8);
        exp_q.push_back(pk(S_FF_01, 1'b1, 2'd3));
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        chk("carry_count", 32'(op_count), 32'h3);

        // Round robin with all requesters valid
        step();
        set_op(0, 8'h10, 8'h01);
        set_op(1, 8'h20, 8'h02);
        set_op(2, 8'h30, 8'h03);
        set_op(3, 8'h40, 8'h04);
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_ready", 32'(req_ready), 32'(1) << (k % 4));
            if (k > 0) chk("rr_valid_held", 32'(resp_valid), 32'h1);
            case (k % 4)
                0: exp_q.push_back(pk(8'h11, 1'b0, 2'd0));
                1: exp_q.push_back(pk(8'h22, 1'b0, 2'd1));
                2: exp_q.push_back(pk(8'h33, 1'b0, 2'd2));
                default: exp_q.push_back(pk(8'h44, 1'b0, 2'd3));
            endcase
            step();
        end
        req_valid = '0;
        step();
        @(negedge clk);
        chk("rr_count", 32'(op_count), 32'd9);

        // Backpressure: ptr=2, fill with requester 0 and stall
        step();
        req_valid  = 4'b0001;
        resp_ready = 1'b0;
        set_op(0, 8'h7F, 8'h01);
        @(negedge clk);
        chk("bp_fill_ready", 32'(req_ready), 32'h1);
        exp_q.push_back(pk(8'h80, 1'b0, 2'd0));
        step();
        req_valid = 4'b0110;
        set_op(1, 8'h05, 8'h06);
        set_op(2, 8'h0A, 8'h0A);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_hold", {21'd0, resp_valid, resp_sum, resp_id}, {21'd0, 1'b1, 8'h80, 2'd0});
            step();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        exp_q.push_back(pk(8'h0B, 1'b0, 2'd1));
        step();

        // Simultaneous drain and grant on requester 2
        req_valid = 4'b0100;
        set_op(2, 8'h01, 8'h01);
        @(negedge clk);
        chk("sim_ready", 32'(req_ready), 32'h4);
        exp_q.push_back(pk(8'h02, 1'b0, 2'd2));
        step();
        req_valid = '0;
        @(negedge clk);
        chk("sim_valid", 32'(resp_valid), 32'h1);
        step();
        @(negedge clk);
        chk("sim_count", 32'(op_count), 32'd12);

        // Reset mid-op: slot full with requester 3, requests pending
        step();
        req_valid  = 4'b1000;
        resp_ready = 1'b0;
        set_op(3, 8'h22, 8'h11);
        @(negedge clk);
        chk("mid_fill_ready", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'b1010;
        rst       = 1'b1;
        @(negedge clk);
        chk("mid_ready_rst", 32'(req_ready), 32'h0);
        chk("mid_valid_pre", 32'(resp_valid), 32'h1);
        step();
        rst        = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("mid_valid_post", 32'(resp_valid), 32'h0);
        chk("mid_count_post", 32'(op_count), 32'h0);
        chk("mid_first_grant", 32'(req_ready), 32'h2);
        exp_q.push_back(pk(8'h0B, 1'b0, 2'd1));
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        chk("mid_count_after", 32'(op_count), 32'h1);
        chk("busy_idle", 32'(busy), 32'h0);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_add_arb.md
Name: tt_add_arb

Overview:
- Round-robin arbiter and sequencer that shares one W-bit adder between NREQ requesters.
- Each requester presents an operand pair under a valid/ready handshake.
- The block grants one requester per cycle, registers that requester's sum, carry and ID into a single-entry response slot, and returns them under valid/ready.
- Sits between the tile's input-decoding logic and the shared adder datapath.

Parameters:
- NREQ, 4, number of requesters; legal 2..8.
- W, 8, operand and sum width.
- IDW, $clog2(NREQ), width of resp_id; derived, not overridden.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept, one-hot or zero, combinational.
- req_a  input  NREQ*W  operand A; requester i at bits [i*W +: W].
- req_b  input  NREQ*W  operand B; same packing.
- resp_valid  output  1  response slot full.
- resp_ready  input  1  consumer accepts response.
- resp_sum  output  W  registered sum (a+b) mod 2^W, or saturated (see Optional Feature).
- resp_carry  output  1  carry-out of the full W+1-bit sum.
- resp_id  output  IDW  index of the requester served.
- op_count  output  16  completed-response counter.
- busy  output  1  resp_valid OR any req_valid.

Behaviour:
- Reset (rst=1 at a clock edge):
  - resp_valid=0, resp_sum=0, resp_carry=0, resp_id=0.
  - op_count=0, round-robin pointer ptr=0.
  - req_ready is forced to 0 while rst=1.
  - Reset mid-operation drops any held response with no completion counted.
- Slot-free condition: slot_free = !resp_valid || resp_ready.
- Arbitration:
  - Only when slot_free.
  - Search req_valid starting at index ptr, ascending, wrapping at NREQ-1 to 0.
  - The first asserted index g gets req_ready[g]=1; every other req_ready bit is 0.
  - With no valid requests, req_ready=0.
  - A requester must hold valid and operands stable until it sees ready.
  - The handshake completes on the edge where req_valid[g] && req_ready[g].
- On grant at edge N:
  - resp_sum/resp_carry are computed from the W+1-bit sum req_a[g]+req_b[g].
  - resp_id=g and resp_valid=1, all visible after edge N (latency 1 cycle).
  - ptr becomes (g+1) mod NREQ. ptr is unchanged when there is no grant.
- Response drain:
  - On an edge with resp_valid && resp_ready, op_count increments; it wraps 0xFFFF to 0x0000.
  - If a new grant occurs on the same edge, the slot reloads and resp_valid stays 1. This gives full throughput: one op per cycle.
  - If there is no grant, resp_valid goes to 0.
- Backpressure:
  - While resp_valid && !resp_ready, req_ready=0.
  - resp_sum, resp_carry and resp_id hold stable.
  - ptr does not move.
- Fairness: any continuously-valid requester is granted within NREQ grants.
- Two-state control, derived from resp_valid:
  - EMPTY goes to FULL on a grant.
  - FULL goes to EMPTY on drain without a grant.
  - FULL stays FULL on drain with a grant, or when stalled.
- Width rules:
  - Sum is computed at W+1 bits; resp_carry is bit W.
  - resp_carry is reported in both build variants.

Optional Feature:
- Macro: TT_ADD_ARB_SAT_EN.
- Defined: when carry=1, resp_sum is forced to all-ones (2^W-1); otherwise resp_sum is the true sum. resp_carry is still reported.
- Undefined: resp_sum = (a+b) mod 2^W (wrap-around).
- Arbitration, latency and handshakes are identical in both builds.

Test Plan:
- Reset, then one request: assert rst 2 cycles; then req_valid=0001, a0=0x12, b0=0x34 -> req_ready=0001 same cycle; next cycle resp_valid=1, resp_sum=0x46, carry=0, id=0; with resp_ready=1, op_count becomes 1.
- Carry/wrap: a=0xF0, b=0x20 -> sum=0x10, carry=1 without TT_ADD_ARB_SAT_EN; sum=0xFF, carry=1 with it.
- Round-robin: req_valid=1111 held, resp_ready=1 -> grant order 0,1,2,3,0,1; resp_valid stays 1 every cycle after the first; op_count=6 after 6 drains.
- Backpressure: slot full, resp_ready=0 for 5 cycles with req_valid=0110 -> req_ready=0000; resp_* stable; ptr unchanged; on release, the next grant follows RR order from the stalled ptr.
- Simultaneous drain and grant: resp_valid=1, resp_ready=1, req_valid[2]=1 (a=0x01, b=0x01) -> the same edge drains and reloads; resp_valid stays 1, resp_sum=0x02, id=2.
- Reset mid-op: rst=1 while resp_valid=1 and requests pending -> the next cycle has resp_valid=0, op_count=0, ptr=0, req_ready=0 during reset; the first grant after reset goes to the lowest valid index.
